// File: rtl/mem_pkg.sv
// Shared types and defaults for main_memory and its word array.
// Defaults mirror the data_cache line geometry.
package mem_pkg;

   localparam int DEF_ADDR_WIDTH  = 32;
   localparam int DEF_DATA_WIDTH  = 32;
   localparam int DEF_DEPTH_WORDS = 1024;
   localparam int DEF_LATENCY     = 10;
   localparam int DEF_LINE_WORDS  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      BURST = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Bit width needed to index n items, never less than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int LINE_OFS_W = clog2_min1(DEF_LINE_WORDS);
   localparam int IDX_W      = clog2_min1(DEF_DEPTH_WORDS);

endpackage

// File: rtl/mem_array.sv
// Single-port word store: synchronous write, combinational read.
// Contents start at zero and are never cleared by reset.
module mem_array
   import mem_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH_WORDS,
   parameter int WIDTH = DEF_DATA_WIDTH,
   parameter int AW    = clog2_min1(DEF_DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    addr_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

   // Commit one word on the write strobe.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/main_memory.sv
// Multi-cycle backing memory: line-fill bursts and word writes
// after a fixed access latency, one request at a time.
module main_memory
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
   parameter int LATENCY     = DEF_LATENCY,
   parameter int LINE_WORDS  = DEF_LINE_WORDS
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                req,
   input  logic                                we,
   input  logic [ADDR_WIDTH-1:0]               addr,
   input  logic [DATA_WIDTH-1:0]               wdata,
   output logic                                busy,
   output logic                                rvalid,
   output logic [DATA_WIDTH-1:0]               rdata,
   output logic [clog2_min1(LINE_WORDS)-1:0]   beat_idx,
   output logic                                done
);

   localparam int OFS_W = clog2_min1(LINE_WORDS);
   localparam int IW    = clog2_min1(DEPTH_WORDS);
   localparam int CNT_W = clog2_min1(LATENCY);

   localparam logic [IW-1:0]    LINE_MASK = IW'(LINE_WORDS - 1);
   localparam logic [OFS_W-1:0] LAST_OFS  = OFS_W'(LINE_WORDS - 1);
   localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(LATENCY - 1);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    we_q, we_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [OFS_W-1:0]        beat_q, beat_d;
   logic                    rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [OFS_W-1:0]        bidx_q, bidx_d;
   logic                    done_q, done_d;

   logic                    wait_exit;
   logic                    arr_we;
   logic [OFS_W-1:0]        rd_ofs;
   logic [IW-1:0]           arr_addr;
   logic [DATA_WIDTH-1:0]   arr_rdata;
   logic                    unused_addr;

   assign unused_addr = ^addr;
   assign wait_exit   = (state_q == WAIT) && (cnt_q == '0);

   // Array port: write address while committing, else next beat.
   always_comb begin
      arr_we   = wait_exit && we_q && !reset;
      rd_ofs   = (state_q == BURST) ? beat_q + OFS_W'(1) : '0;
      arr_addr = arr_we ? idx_q
                        : ((idx_q & ~LINE_MASK) | IW'(rd_ofs));
   end

   mem_array #(
      .DEPTH (DEPTH_WORDS),
      .WIDTH (DATA_WIDTH),
      .AW    (IW)
   ) u_array (
      .clk     (clk),
      .we_i    (arr_we),
      .addr_i  (arr_addr),
      .wdata_i (wdata_q),
      .rdata_o (arr_rdata)
   );

   // Request sequencing and registered beat outputs.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      idx_d    = idx_q;
      wdata_d  = wdata_q;
      beat_d   = beat_q;
      rvalid_d = 1'b0;
      rdata_d  = rdata_q;
      bidx_d   = bidx_q;
      done_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               state_d = WAIT;
               cnt_d   = CNT_INIT;
               we_d    = we;
               idx_d   = addr[IW+1:2];
               wdata_d = wdata;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               if (we_q) begin
                  done_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d  = (LINE_WORDS == 1) ? DONE : BURST;
                  beat_d   = '0;
                  rvalid_d = 1'b1;
                  rdata_d  = arr_rdata;
                  bidx_d   = '0;
                  done_d   = (LINE_WORDS == 1);
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         BURST: begin
            if (beat_q == LAST_OFS) begin
               state_d = DONE;
            end else begin
               beat_d   = beat_q + OFS_W'(1);
               rvalid_d = 1'b1;
               rdata_d  = arr_rdata;
               bidx_d   = beat_q + OFS_W'(1);
               done_d   = ((beat_q + OFS_W'(1)) == LAST_OFS);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         we_q     <= 1'b0;
         idx_q    <= '0;
         wdata_q  <= '0;
         beat_q   <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         bidx_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         we_q     <= we_d;
         idx_q    <= idx_d;
         wdata_q  <= wdata_d;
         beat_q   <= beat_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         bidx_q   <= bidx_d;
         done_q   <= done_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign rvalid   = rvalid_q;
   assign rdata    = rdata_q;
   assign beat_idx = bidx_q;
   assign done     = done_q;

endmodule

// File: tb/tb_main_memory.sv
// Bench for main_memory: timing model plus directed line/word tests.
// Expected values come from request timing arithmetic and literals.
module tb_main_memory;

   localparam int DEPTH = 1024;
   localparam int LAT   = 10;
   localparam int LW    = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        rvalid;
   logic [31:0] rdata;
   logic [1:0]  beat_idx;
   logic        done;

   int checks   = 0;
   int failures = 0;

   int unsigned m_mem [DEPTH];

   logic [31:0] cap_beats [LW];
   int          cap_done;
   int          cap_first;
   int          cap_n;

   always #5 clk = ~clk;

   main_memory #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (LAT),
      .LINE_WORDS  (LW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .we       (we),
      .addr     (addr),
      .wdata    (wdata),
      .busy     (busy),
      .rvalid   (rvalid),
      .rdata    (rdata),
      .beat_idx (beat_idx),
      .done     (done)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % DEPTH);
   endfunction

   // Model: outputs derived from edges elapsed since accept.
   bit          m_act = 1'b0;
   bit          m_we;
   int          m_idx;
   int unsigned m_wd;
   int          m_edge = 0;
   int          m_acc;
   int          m_end;
   int          m_d;
   bit          e_busy;
   bit          e_rv;
   bit          e_done;
   int unsigned e_rd = 0;
   int          e_bi = 0;
   bit          s_rst;
   bit          s_req;
   bit          s_we;
   logic [31:0] s_a;
   logic [31:0] s_d;

   initial begin : cmp
      forever begin
         @(posedge clk);
         s_rst = reset;
         s_req = req;
         s_we  = we;
         s_a   = addr;
         s_d   = wdata;
         m_edge++;
         e_busy = 1'b0;
         e_rv   = 1'b0;
         e_done = 1'b0;
         if (s_rst) begin
            m_act = 1'b0;
            e_rd  = 0;
            e_bi  = 0;
         end else begin
            if (m_act) begin
               m_d   = m_edge - m_acc;
               m_end = m_we ? LAT : LAT + LW;
               if (m_d > m_end) m_act = 1'b0;
            end else if (s_req) begin
               m_act = 1'b1;
               m_acc = m_edge;
               m_we  = s_we;
               m_idx = widx(s_a);
               m_wd  = s_d;
            end
            if (m_act) begin
               m_d    = m_edge - m_acc;
               e_busy = 1'b1;
               if (m_we) begin
                  if (m_d == LAT) begin
                     m_mem[m_idx] = m_wd;
                     e_done = 1'b1;
                  end
               end else if (m_d >= LAT && m_d < LAT + LW) begin
                  e_rv   = 1'b1;
                  e_bi   = m_d - LAT;
                  e_rd   = m_mem[m_idx - (m_idx % LW) + e_bi];
                  e_done = (e_bi == LW - 1);
               end
            end
         end
         #1;
         chk("busy", 32'(busy), 32'(e_busy));
         chk("rvalid", 32'(rvalid), 32'(e_rv));
         chk("done", 32'(done), 32'(e_done));
         chk("rdata", rdata, e_rd);
         chk("beat_idx", 32'(beat_idx), 32'(e_bi));
      end
   end

   // Issue one request and record what the DUT returns for it.
   task automatic run_req(input logic w, input logic [31:0] a,
                          input logic [31:0] dv, input int poke_at,
                          input bit rst_b1);
      int cnt;
      bit fin;
      for (int i = 0; i < LW; i++) cap_beats[i] = 32'hDEADBEEF;
      cap_done  = 0;
      cap_first = -1;
      cap_n     = 0;
      req   = 1'b1;
      we    = w;
      addr  = a;
      wdata = dv;
      @(posedge clk);
      #2;
      req   = 1'b0;
      we    = 1'b0;
      addr  = '0;
      wdata = '0;
      cnt = 1;
      fin = 1'b0;
      while (!fin && cnt < 100) begin
         if (rvalid) begin
            if (cap_first < 0) cap_first = int'(beat_idx);
            cap_beats[beat_idx] = rdata;
            cap_n++;
         end
         if (done) cap_done = cnt;
         if (!busy) begin
            fin = 1'b1;
         end else begin
            if (cnt == poke_at) begin
               req   = 1'b1;
               we    = 1'b1;
               addr  = 32'h4;
               wdata = 32'hFF;
            end else begin
               req   = 1'b0;
               we    = 1'b0;
               addr  = '0;
               wdata = '0;
            end
            reset = (rst_b1 && rvalid && beat_idx == 2'd1);
            @(posedge clk);
            #2;
            cnt++;
         end
      end
      if (!fin) begin
         checks++;
         failures++;
         $display("FAIL timeout: busy still %0b after %0d cycles",
                  busy, cnt);
      end
      req   = 1'b0;
      we    = 1'b0;
      reset = 1'b0;
   endtask

   task automatic chk_line(input string nm, input logic [31:0] b0,
                           input logic [31:0] b1, input logic [31:0] b2,
                           input logic [31:0] b3);
      chk({nm, "_b0"}, cap_beats[0], b0);
      chk({nm, "_b1"}, cap_beats[1], b1);
      chk({nm, "_b2"}, cap_beats[2], b2);
      chk({nm, "_b3"}, cap_beats[3], b3);
   endtask

   initial begin
      reset = 1'b1;
      req   = 1'b1;
      we    = 1'b0;
      addr  = '0;
      wdata = '0;
      repeat (3) begin
         @(posedge clk);
         #2;
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_rvalid", 32'(rvalid), 32'd0);
         chk("rst_done", 32'(done), 32'd0);
         chk("rst_rdata", rdata, 32'd0);
         chk("rst_bidx", 32'(beat_idx), 32'd0);
      end
      reset = 1'b0;
      req   = 1'b0;
      @(posedge clk);
      #2;
      chk("post_rst_busy", 32'(busy), 32'd0);

      run_req(1'b1, 32'h4, 32'd7, 0, 1'b0);
      chk("wr_done_lat", cap_done, 32'd11);

      run_req(1'b0, 32'h0, 32'd0, 0, 1'b0);
      chk_line("rd0", 32'd0, 32'd7, 32'd0, 32'd0);
      chk("rd0_done_lat", cap_done, 32'd14);
      chk("rd0_nbeats", cap_n, 32'd4);
      chk("rd0_first", cap_first, 32'd0);

      run_req(1'b1, 32'h20, 32'd3, 0, 1'b0);
      chk("wr20_done_lat", cap_done, 32'd11);
      run_req(1'b0, 32'h2C, 32'd0, 0, 1'b0);
      chk_line("rd2c", 32'd3, 32'd0, 32'd0, 32'd0);
      chk("rd2c_first", cap_first, 32'd0);

      run_req(1'b0, 32'h0, 32'd0, 3, 1'b0);
      chk_line("poke", 32'd0, 32'd7, 32'd0, 32'd0);
      run_req(1'b0, 32'h4, 32'd0, 0, 1'b0);
      chk("poke_w1", cap_beats[1], 32'd7);

      run_req(1'b1, 32'(DEPTH * 4 + 4), 32'hA, 0, 1'b0);
      run_req(1'b0, 32'h4, 32'd0, 0, 1'b0);
      chk("wrap_w1", cap_beats[1], 32'hA);

      run_req(1'b0, 32'h0, 32'd0, 0, 1'b1);
      chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_nodone", cap_done, 32'd0);
      chk("mid_rst_nbeats", cap_n, 32'd2);
      run_req(1'b0, 32'h0, 32'd0, 0, 1'b0);
      chk_line("after_rst", 32'd0, 32'hA, 32'd0, 32'd0);
      chk("after_rst_lat", cap_done, 32'd14);

      chk("model_w1", m_mem[1], 32'hA);
      chk("model_w8", m_mem[8], 32'd3);
      chk("model_w0", m_mem[0], 32'd0);

      repeat (3) @(posedge clk);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
